// File: rtl/aer_pkg.sv
// Shared definitions for the spike AER encoder slice.
// Contents:
//   N_NEURONS, IDX_WIDTH, TS_WIDTH, DATA_WIDTH : sizing of spike vector and AER word
//   aer_event_t : AER word layout {ts, idx}, ts in the upper bits
//   aer_state_t : serialiser state (IDLE, SCAN)
package aer_pkg;

  localparam int N_NEURONS  = 64;
  localparam int IDX_WIDTH  = $clog2(N_NEURONS);
  localparam int TS_WIDTH   = 10;
  localparam int DATA_WIDTH = TS_WIDTH + IDX_WIDTH;

  typedef struct packed {
    logic [TS_WIDTH-1:0]  ts;
    logic [IDX_WIDTH-1:0] idx;
  } aer_event_t;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } aer_state_t;

endpackage

// File: rtl/lsb_priority_encoder.sv
// Combinational lowest-set-bit priority encoder.
// Ports:
//   vec_i    : input vector
//   idx_o    : index of the lowest set bit (0 when vec_i is zero)
//   any_o    : at least one bit set
//   onehot_o : exactly one bit set
module lsb_priority_encoder #(
  parameter int N = 64,
  parameter int W = 6
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         any_o,
  output logic         onehot_o
);

  always_comb begin
    idx_o = '0;
    // Scan from the top so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = W'(i);
    end
  end

  assign any_o    = |vec_i;
  // Clearing the lowest set bit leaves zero only for a single-bit vector.
  assign onehot_o = any_o && ((vec_i & (vec_i - N'(1))) == '0);

endmodule

// File: rtl/spike_aer_encoder.sv
// Spike-vector to AER serialiser feeding the spike-event FIFO.
// Latches the spike vector on each accepted timestep tick and emits one
// {timestamp, neuron index} word per cycle, lowest index first, holding the
// word while the FIFO is full.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   tick         : 1-cycle timestep strobe, spikes valid with it
//   spikes       : spike flags of the current timestep
//   fifo_full    : FIFO full flag (combinational from FIFO)
//   fifo_wr      : FIFO write request
//   fifo_data    : AER word {frame_ts, idx}
//   clr_overrun  : clears the sticky overrun flag
//   busy         : a frame is being serialised
//   overrun      : sticky, a tick was dropped while busy
//   event_cnt    : words accepted by the FIFO, saturating
module spike_aer_encoder
  import aer_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic [N_NEURONS-1:0]  spikes,
  input  logic                  fifo_full,
  output logic                  fifo_wr,
  output logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  clr_overrun,
  output logic                  busy,
  output logic                  overrun,
  output logic [15:0]           event_cnt
);

  aer_state_t           state_q, state_d;
  logic [N_NEURONS-1:0] pending_q, pending_d;
  logic [TS_WIDTH-1:0]  ts_cnt_q, frame_ts_q;
  logic                 overrun_q;
  logic [15:0]          event_cnt_q;

  logic [IDX_WIDTH-1:0] enc_idx;
  logic                 enc_any;
  logic                 enc_onehot;
  logic                 acc;
  logic                 last_acc;
  logic                 tick_ok;
  aer_event_t           word;

  lsb_priority_encoder #(
    .N (N_NEURONS),
    .W (IDX_WIDTH)
  ) u_enc (
    .vec_i    (pending_q),
    .idx_o    (enc_idx),
    .any_o    (enc_any),
    .onehot_o (enc_onehot)
  );

  // pending is never empty in SCAN; enc_any just guards against a stray state.
  assign fifo_wr  = (state_q == SCAN) && enc_any;
  assign acc      = fifo_wr && !fifo_full;
  assign last_acc = acc && enc_onehot;
  // A tick arriving with the final word of a frame starts the next frame directly.
  assign tick_ok  = tick && ((state_q == IDLE) || last_acc);

  assign word.ts   = frame_ts_q;
  assign word.idx  = enc_idx;
  assign fifo_data = fifo_wr ? word : '0;
  assign busy      = (state_q == SCAN);
  assign overrun   = overrun_q;
  assign event_cnt = event_cnt_q;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    if (acc) begin
      pending_d[enc_idx] = 1'b0;
      if (last_acc) state_d = IDLE;
    end
    if (tick_ok) begin
      pending_d = spikes;
      state_d   = (spikes != '0) ? SCAN : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      ts_cnt_q    <= '0;
      frame_ts_q  <= '0;
      overrun_q   <= 1'b0;
      event_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      // Counts every tick, dropped or not, so timestamps track real time.
      if (tick)    ts_cnt_q   <= ts_cnt_q + 1'b1;
      if (tick_ok) frame_ts_q <= ts_cnt_q;
      if (tick && !tick_ok) overrun_q <= 1'b1;
      else if (clr_overrun) overrun_q <= 1'b0;
      if (acc && (event_cnt_q != 16'hFFFF)) event_cnt_q <= event_cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_spike_aer_encoder.sv
module tb_spike_aer_encoder;
  import aer_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  tick = 1'b0;
  logic [N_NEURONS-1:0]  spikes = '0;
  logic                  fifo_full = 1'b0;
  logic                  fifo_wr;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  clr_overrun = 1'b0;
  logic                  busy;
  logic                  overrun;
  logic [15:0]           event_cnt;

  int total = 0;
  int bad   = 0;

  spike_aer_encoder dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .spikes      (spikes),
    .fifo_full   (fifo_full),
    .fifo_wr     (fifo_wr),
    .fifo_data   (fifo_data),
    .clr_overrun (clr_overrun),
    .busy        (busy),
    .overrun     (overrun),
    .event_cnt   (event_cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] w(input int ts, input int idx);
    return (ts << 6) | idx;
  endfunction

  initial begin
    // reset state
    cyc(); cyc();
    reset = 1'b0;
    #1;
    chk("rst_wr", 32'(fifo_wr), 0);
    chk("rst_data", 32'(fifo_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovr", 32'(overrun), 0);
    chk("rst_cnt", 32'(event_cnt), 0);

    // 1: frame 0x91 -> idx 0,4,7 at ts 0
    tick = 1'b1; spikes = 64'h91;
    cyc();
    tick = 1'b0; #1;
    chk("t1_wr0", 32'(fifo_wr), 1);
    chk("t1_d0", 32'(fifo_data), w(0, 0));
    cyc();
    chk("t1_d1", 32'(fifo_data), w(0, 4));
    chk("t1_busy", 32'(busy), 1);
    cyc();
    chk("t1_d2", 32'(fifo_data), w(0, 7));
    cyc();
    chk("t1_wr_end", 32'(fifo_wr), 0);
    chk("t1_busy_end", 32'(busy), 0);
    chk("t1_cnt", 32'(event_cnt), 3);

    // 2: frame 0x3 at ts 1 with FIFO full for 5 cycles
    tick = 1'b1; spikes = 64'h3; fifo_full = 1'b1;
    cyc();
    tick = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_wr", 32'(fifo_wr), 1);
      chk("t2_hold_d", 32'(fifo_data), w(1, 0));
      cyc();
    end
    fifo_full = 1'b0; #1;
    chk("t2_d0", 32'(fifo_data), w(1, 0));
    cyc();
    chk("t2_d1", 32'(fifo_data), w(1, 1));
    cyc();
    chk("t2_wr_end", 32'(fifo_wr), 0);
    chk("t2_cnt", 32'(event_cnt), 5);

    // 3: tick while 4 pending -> dropped, overrun
    tick = 1'b1; spikes = 64'hF0;
    cyc();
    tick = 1'b0; #1;
    chk("t3_d0", 32'(fifo_data), w(2, 4));
    tick = 1'b1; spikes = 64'hFFFF;
    cyc();
    tick = 1'b0; #1;
    chk("t3_ovr", 32'(overrun), 1);
    chk("t3_d1", 32'(fifo_data), w(2, 5));
    cyc();
    chk("t3_d2", 32'(fifo_data), w(2, 6));
    cyc();
    chk("t3_d3", 32'(fifo_data), w(2, 7));
    cyc();
    chk("t3_wr_end", 32'(fifo_wr), 0);
    chk("t3_cnt", 32'(event_cnt), 9);
    chk("t3_ovr_sticky", 32'(overrun), 1);
    clr_overrun = 1'b1;
    cyc();
    clr_overrun = 1'b0; #1;
    chk("t3_ovr_clr", 32'(overrun), 0);

    // 4: dropped tick still advanced ts; tick on last_acc chains frames
    tick = 1'b1; spikes = 64'h3;
    cyc();
    tick = 1'b0; #1;
    chk("t4_d0", 32'(fifo_data), w(4, 0));
    cyc();
    chk("t4_d1", 32'(fifo_data), w(4, 1));
    tick = 1'b1; spikes = 64'h4;
    cyc();
    tick = 1'b0; #1;
    chk("t4_wr_cont", 32'(fifo_wr), 1);
    chk("t4_d2", 32'(fifo_data), w(5, 2));
    chk("t4_ovr", 32'(overrun), 0);
    cyc();
    chk("t4_wr_end", 32'(fifo_wr), 0);
    chk("t4_cnt", 32'(event_cnt), 12);

    // 6: reset mid-frame
    tick = 1'b1; spikes = 64'hFF;
    cyc();
    tick = 1'b0; #1;
    chk("t6_busy", 32'(busy), 1);
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0; #1;
    chk("t6_wr", 32'(fifo_wr), 0);
    chk("t6_busy0", 32'(busy), 0);
    chk("t6_cnt", 32'(event_cnt), 0);
    chk("t6_ovr", 32'(overrun), 0);
    tick = 1'b1; spikes = 64'h2;
    cyc();
    tick = 1'b0; #1;
    chk("t6_d0", 32'(fifo_data), w(0, 1));
    cyc();
    chk("t6_wr_end", 32'(fifo_wr), 0);
    chk("t6_cnt1", 32'(event_cnt), 1);

    // 5: 1025 ticks on neuron 63, timestamp wraps 1023 -> 0
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    spikes = 64'h8000_0000_0000_0000;
    for (int i = 0; i < 1025; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0; #1;
      chk("t5_d", 32'(fifo_data), w(i % 1024, 63));
      cyc();
    end
    chk("t5_cnt", 32'(event_cnt), 1025);
    chk("t5_ovr", 32'(overrun), 0);
    chk("t5_wr_end", 32'(fifo_wr), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
